// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: the fetch/decode payload record and instruction constants.
package cpu_types_pkg;

   // Instruction word presented to decode when the fetch faulted.
   localparam logic [31:0] INST_ZERO = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        valid;
      logic        fault;
   } if_id_t;

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: one outstanding imem request, single output register to decode,
// redirect support with wrong-path response dropping.
module ifu_fetch
   import cpu_types_pkg::*;
#(
   parameter int               XLEN     = 32,
   parameter logic [XLEN-1:0]  RESET_PC = 32'h8000_0000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_resp_valid,
   output logic            imem_resp_ready,
   input  logic [31:0]     imem_resp_data,
   input  logic            imem_resp_err,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [31:0]     out_inst,
   output logic            out_fault
);

   typedef enum logic [1:0] {S_REQ, S_RESP, S_OUT} ifu_state_e;

   ifu_state_e      r_state, w_state_next;
   logic [XLEN-1:0] r_pc, w_pc_next;
   logic [XLEN-1:0] r_pend_pc, w_pend_pc_next;
   logic            r_drop, w_drop_next;
   logic            w_out_load;
   logic [XLEN-1:0] r_out_pc;
   logic [31:0]     r_out_inst;
   logic            r_out_fault;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_REQ;
         r_pc        <= RESET_PC;
         r_pend_pc   <= '0;
         r_drop      <= 1'b0;
         r_out_pc    <= '0;
         r_out_inst  <= INST_ZERO;
         r_out_fault <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_pc      <= w_pc_next;
         r_pend_pc <= w_pend_pc_next;
         r_drop    <= w_drop_next;
         if (w_out_load) begin
            r_out_pc    <= r_pc;
            r_out_inst  <= imem_resp_err ? INST_ZERO : imem_resp_data;
            r_out_fault <= imem_resp_err;
         end
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_pc_next      = r_pc;
      w_pend_pc_next = r_pend_pc;
      w_drop_next    = r_drop;
      w_out_load     = 1'b0;
      unique case (r_state)
         S_REQ: begin
            // The request already on the bus is allowed to complete; its response is dropped.
            if (redirect_valid) begin
               w_pend_pc_next = redirect_pc;
               w_drop_next    = 1'b1;
            end
            if (imem_req_ready) begin
               w_state_next = S_RESP;
            end
         end
         S_RESP: begin
            if (redirect_valid) begin
               w_pend_pc_next = redirect_pc;
               w_drop_next    = 1'b1;
            end
            if (imem_resp_valid) begin
               if (r_drop || redirect_valid) begin
                  w_pc_next    = redirect_valid ? redirect_pc : r_pend_pc;
                  w_drop_next  = 1'b0;
                  w_state_next = S_REQ;
               end else begin
                  w_out_load   = 1'b1;
                  w_state_next = S_OUT;
               end
            end
         end
         S_OUT: begin
            // A redirect beats PC+4 whether or not decode took the held instruction.
            if (redirect_valid) begin
               w_pc_next    = redirect_pc;
               w_state_next = S_REQ;
            end else if (out_ready) begin
               w_pc_next    = r_pc + XLEN'(4);
               w_state_next = S_REQ;
            end
         end
         default: begin
            w_state_next = S_REQ;
         end
      endcase
   end

   assign imem_req_valid  = !rst && (r_state == S_REQ);
   assign imem_req_addr   = {r_pc[XLEN-1:2], 2'b00};
   assign imem_resp_ready = !rst && (r_state == S_RESP);
   assign out_valid       = !rst && (r_state == S_OUT);
   assign out_pc          = r_out_pc;
   assign out_inst        = r_out_inst;
   assign out_fault       = r_out_fault;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: cycle table of directed corners, a reset-in-flight sequence,
// and a randomized run against a stream-level model of delivered instructions.
module tb_ifu_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic        imem_resp_ready;
   logic [31:0] imem_resp_data;
   logic        imem_resp_err;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic        out_fault;

   int tests = 0;
   int fails = 0;

   ifu_fetch dut (
      .clk             (clk),
      .rst             (rst),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_ready (imem_resp_ready),
      .imem_resp_data  (imem_resp_data),
      .imem_resp_err   (imem_resp_err),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_pc          (out_pc),
      .out_inst        (out_inst),
      .out_fault       (out_fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        rv;
      logic [31:0] rpc;
      logic        qrdy;
      logic        pv;
      logic [31:0] pdata;
      logic        perr;
      logic        ordy;
      logic        qv;
      logic [31:0] qaddr;
      logic        pr;
      logic        ov;
      logic [31:0] opc;
      logic [31:0] oinst;
      logic        ofault;
   } vec_t;

   function automatic vec_t mk(logic rv, logic [31:0] rpc, logic qrdy, logic pv, logic [31:0] pdata,
                               logic perr, logic ordy, logic qv, logic [31:0] qaddr, logic pr,
                               logic ov, logic [31:0] opc, logic [31:0] oinst, logic ofault);
      vec_t v;
      v.rv = rv; v.rpc = rpc; v.qrdy = qrdy; v.pv = pv; v.pdata = pdata; v.perr = perr;
      v.ordy = ordy; v.qv = qv; v.qaddr = qaddr; v.pr = pr; v.ov = ov; v.opc = opc;
      v.oinst = oinst; v.ofault = ofault;
      return v;
   endfunction

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   function automatic logic mem_err(input logic [31:0] a);
      return a[6:2] == 5'd7;
   endfunction

   task automatic drive_idle();
      redirect_valid  = 1'b0;
      redirect_pc     = 32'h0;
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
      imem_resp_err   = 1'b0;
      out_ready       = 1'b0;
   endtask

   vec_t tbl [0:26];

   initial begin
      logic [31:0] exp_pc;
      logic [31:0] a_al;
      logic [31:0] mem_addr;
      logic        mem_busy;
      int unsigned mem_delay;
      int          idle;
      int          n_deliv;

      // cycle-by-cycle table; outputs are those of the cycle in which the inputs are applied
      tbl[0]  = mk(0, 0, 1, 0, 0, 0, 0,            1, 32'h8000_0000, 0, 0, 0, 0, 0);
      tbl[1]  = mk(0, 0, 0, 1, 32'h1111_1111, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 1, 32'h8000_0000, 32'h1111_1111, 0);
      tbl[3]  = mk(0, 0, 1, 0, 0, 0, 0,            0, 0, 0, 1, 32'h8000_0000, 32'h1111_1111, 0);
      tbl[4]  = mk(0, 0, 1, 0, 0, 0, 0,            0, 0, 0, 1, 32'h8000_0000, 32'h1111_1111, 0);
      tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 1, 32'h8000_0000, 32'h1111_1111, 0);
      tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 1, 32'h8000_0000, 32'h1111_1111, 0);
      tbl[7]  = mk(0, 0, 0, 0, 0, 0, 1,            0, 0, 0, 1, 32'h8000_0000, 32'h1111_1111, 0);
      tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0,            1, 32'h8000_0004, 0, 0, 0, 0, 0);
      tbl[9]  = mk(0, 0, 1, 0, 0, 0, 0,            1, 32'h8000_0004, 0, 0, 0, 0, 0);
      tbl[10] = mk(0, 0, 0, 0, 0, 0, 0,            0, 0, 1, 0, 0, 0, 0);
      tbl[11] = mk(1, 32'h8000_0100, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      tbl[12] = mk(0, 0, 0, 0, 0, 0, 0,            0, 0, 1, 0, 0, 0, 0);
      tbl[13] = mk(0, 0, 0, 1, 32'hDEAD_BEEF, 0, 1, 0, 0, 1, 0, 0, 0, 0);
      tbl[14] = mk(0, 0, 1, 0, 0, 0, 1,            1, 32'h8000_0100, 0, 0, 0, 0, 0);
      tbl[15] = mk(0, 0, 0, 1, 32'h2222_2222, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      tbl[16] = mk(1, 32'h8000_0020, 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h8000_0100, 32'h2222_2222, 0);
      tbl[17] = mk(0, 0, 1, 0, 0, 0, 0,            1, 32'h8000_0020, 0, 0, 0, 0, 0);
      tbl[18] = mk(0, 0, 0, 1, 32'h3333_3333, 1, 0, 0, 0, 1, 0, 0, 0, 0);
      tbl[19] = mk(0, 0, 0, 0, 0, 0, 1,            0, 0, 0, 1, 32'h8000_0020, 32'h0, 1);
      tbl[20] = mk(1, 32'h8000_0013, 1, 0, 0, 0, 0, 1, 32'h8000_0024, 0, 0, 0, 0, 0);
      tbl[21] = mk(0, 0, 0, 1, 32'h4444_4444, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      tbl[22] = mk(0, 0, 1, 0, 0, 0, 0,            1, 32'h8000_0010, 0, 0, 0, 0, 0);
      tbl[23] = mk(0, 0, 0, 1, 32'h5555_5555, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      tbl[24] = mk(1, 32'h8000_0040, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h8000_0013, 32'h5555_5555, 0);
      tbl[25] = mk(0, 0, 1, 0, 0, 0, 0,            1, 32'h8000_0040, 0, 0, 0, 0, 0);
      tbl[26] = mk(0, 0, 0, 0, 0, 0, 0,            0, 0, 1, 0, 0, 0, 0);

      rst = 1'b1;
      drive_idle();
      repeat (3) @(posedge clk);
      #1;
      chk("reset req_valid", {31'b0, imem_req_valid}, 32'd0);
      chk("reset resp_ready", {31'b0, imem_resp_ready}, 32'd0);
      chk("reset out_valid", {31'b0, out_valid}, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 27; i++) begin
         @(posedge clk);
         #1;
         redirect_valid  = tbl[i].rv;
         redirect_pc     = tbl[i].rpc;
         imem_req_ready  = tbl[i].qrdy;
         imem_resp_valid = tbl[i].pv;
         imem_resp_data  = tbl[i].pdata;
         imem_resp_err   = tbl[i].perr;
         out_ready       = tbl[i].ordy;
         #1;
         chk($sformatf("row%0d req_valid", i), {31'b0, imem_req_valid}, {31'b0, tbl[i].qv});
         if (tbl[i].qv)
            chk($sformatf("row%0d req_addr", i), imem_req_addr, tbl[i].qaddr);
         chk($sformatf("row%0d resp_ready", i), {31'b0, imem_resp_ready}, {31'b0, tbl[i].pr});
         chk($sformatf("row%0d out_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].ov});
         if (tbl[i].ov) begin
            chk($sformatf("row%0d out_pc", i), out_pc, tbl[i].opc);
            chk($sformatf("row%0d out_inst", i), out_inst, tbl[i].oinst);
            chk($sformatf("row%0d out_fault", i), {31'b0, out_fault}, {31'b0, tbl[i].ofault});
         end
      end

      // reset while waiting for a response; the stale response must not be consumed
      @(posedge clk);
      #1;
      drive_idle();
      rst = 1'b1;
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'h6666_6666;
      imem_req_ready  = 1'b1;
      out_ready       = 1'b1;
      #1;
      chk("rst resp_ready", {31'b0, imem_resp_ready}, 32'd0);
      @(posedge clk);
      #1;
      chk("rst+1 resp_ready", {31'b0, imem_resp_ready}, 32'd0);
      chk("rst+1 out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst+1 req_valid", {31'b0, imem_req_valid}, 32'd0);
      rst = 1'b0;
      imem_resp_valid = 1'b0;
      #1;
      chk("restart req_valid", {31'b0, imem_req_valid}, 32'd1);
      chk("restart req_addr", imem_req_addr, 32'h8000_0000);
      @(posedge clk);
      #1;
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'h7777_7777;
      imem_req_ready  = 1'b0;
      #1;
      chk("restart resp_ready", {31'b0, imem_resp_ready}, 32'd1);
      @(posedge clk);
      #1;
      imem_resp_valid = 1'b0;
      out_ready = 1'b0;
      #1;
      chk("restart out_valid", {31'b0, out_valid}, 32'd1);
      chk("restart out_pc", out_pc, 32'h8000_0000);
      chk("restart out_inst", out_inst, 32'h7777_7777);

      // randomized run: model tracks only which PC decode should receive next
      @(posedge clk);
      #1;
      drive_idle();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_pc    = 32'h8000_0000;
      mem_busy  = 1'b0;
      mem_addr  = 32'h0;
      mem_delay = 0;
      idle      = 0;
      n_deliv   = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(posedge clk);
         #1;
         imem_resp_valid = 1'b0;
         imem_resp_data  = $urandom;
         imem_resp_err   = 1'($urandom_range(0, 1));
         if (mem_busy) begin
            if (mem_delay > 0) begin
               mem_delay--;
            end else begin
               imem_resp_valid = 1'b1;
               imem_resp_data  = mem_data(mem_addr);
               imem_resp_err   = mem_err(mem_addr);
            end
         end
         imem_req_ready = ($urandom_range(0, 3) != 0);
         out_ready      = ($urandom_range(0, 9) < 7);
         redirect_valid = ($urandom_range(0, 11) == 0);
         redirect_pc    = (($urandom_range(0, 4) == 0) ? 32'hFFFF_FF00 : 32'h8000_0000)
                          | ($urandom & 32'h0000_00FC)
                          | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
         #1;
         if (imem_req_valid && imem_req_ready) begin
            chk("rnd one outstanding", {31'b0, mem_busy}, 32'd0);
            chk("rnd addr aligned", {30'b0, imem_req_addr[1:0]}, 32'd0);
            mem_busy  = 1'b1;
            mem_addr  = imem_req_addr;
            mem_delay = $urandom_range(0, 2);
         end
         if (imem_resp_valid && imem_resp_ready)
            mem_busy = 1'b0;
         idle++;
         if (out_valid && out_ready) begin
            a_al = {exp_pc[31:2], 2'b00};
            chk("rnd out_pc", out_pc, exp_pc);
            chk("rnd out_fault", {31'b0, out_fault}, {31'b0, mem_err(a_al)});
            chk("rnd out_inst", out_inst, mem_err(a_al) ? 32'h0 : mem_data(a_al));
            $display("[TB] deliver pc=%08h inst=%08h fault=%0d", out_pc, out_inst, out_fault);
            exp_pc = exp_pc + 32'd4;
            n_deliv++;
            idle = 0;
         end
         if (redirect_valid)
            exp_pc = redirect_pc;
         if (idle > 200) begin
            tests++;
            fails++;
            $display("FAIL rnd watchdog: no delivery for %0d cycles, expected one", idle);
            break;
         end
      end
      chk("rnd enough deliveries", {31'b0, n_deliv >= 200}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
